// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier display path.
package mult_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned DEFAULT_BIN_W  = 15;
  localparam int unsigned DEFAULT_DIGITS = 5;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFinish
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a digit that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import mult_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Conditional +3; digits entering here never exceed 9, so no overflow.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle shift-and-add-3 binary to BCD converter. The result register is
// only written on completion, so the display never sees partial scratch values.
module seq_bin_to_bcd
  import mult_pkg::*;
#(
  parameter int unsigned BIN_W  = DEFAULT_BIN_W,
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [BIN_W-1:0]              bin_i,
  input  logic                          sign_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          sign_o,
  output logic                          valid_o
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  conv_state_e     state_q, state_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BcdW-1:0]  scratch_q, scratch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_lat_q, sign_lat_d;
  logic [BcdW-1:0]  bcd_q, bcd_d;
  logic             sign_out_q, sign_out_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;

  logic [BcdW-1:0]  adj;

  // All scratch digits are corrected in parallel before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state logic: accept in idle, shift BIN_W times, then publish the result.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    bcd_d      = bcd_q;
    sign_out_d = sign_out_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          shreg_d    = bin_i;
          scratch_d  = '0;
          sign_lat_d = sign_i;
          cnt_d      = CntW'(BIN_W);
          state_d    = StShift;
        end
      end
      StShift: begin
        // Bits leaving the top digit are always zero given enough digits.
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        bcd_d      = scratch_q;
        sign_out_d = sign_lat_q;
        done_d     = 1'b1;
        valid_d    = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      bcd_q      <= '0;
      sign_out_q <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      bcd_q      <= bcd_d;
      sign_out_q <= sign_out_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy_o  = (state_q != StIdle);
    done_o  = done_q;
    bcd_o   = bcd_q;
    sign_o  = sign_out_q;
    valid_o = valid_q;
  end

endmodule
